gcd_operand_feeder: RTL and testbench
=====================================

// Module: gcd_operand_feeder
// PURPOSE
//  Front end for the subtractive GCD engine (controller + gcd_datapath).
//  Accepts operand pairs over a valid/ready stream and buffers them in a small FIFO.
//  Serialises each pair onto the shared 16-bit data_in bus with a start pulse,
//  waits for done, then returns the result over a valid/ready output stream.
//  Zero operands bypass the engine, because subtraction never terminates on 0.
// PARAMETERS
//  WIDTH  16  operand/result width; must match the datapath bus
//  DEPTH  4   pair-FIFO entries; power of 2, >=2
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      upstream pair valid
//  in_ready   out  1      FIFO can accept a pair (= !full)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  data_in    out  WIDTH  to datapath data_in (through mux_load)
//  start      out  1      to controller; one-cycle pulse
//  gcd_done   in   1      from controller; result valid on A_out
//  gcd_result in   WIDTH  datapath A_out
//  res_valid  out  1      result available
//  res_ready  in   1      downstream accepts result
//  res_data   out  WIDTH  GCD result
//  busy       out  1      FSM not in IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset (async assert, sync deassert by the same rst_n as the controller):
//   FSM->IDLE; FIFO empty; start=0; data_in=0; res_valid=0; res_data=0; busy=0; in_ready=1.
//  FIFO:
//   - push on in_valid&&in_ready; in_ready=!full, registered count.
//   - In the FIFO, pop and push may occur in the same cycle; the count is unchanged.
//   - A pushed pair is visible to the FSM the next cycle (no fall-through).
//   - Pointers wrap modulo DEPTH.
//  FSM (one-hot or binary; encodings in package):
//   - IDLE: if !empty -> pop into op_a/op_b.
//     -> BYPASS if op_a==0||op_b==0, else -> SEND_A.
//   - SEND_A: start=1, data_in=op_a (one cycle) -> SEND_B.
//   - SEND_B: start=0, data_in=op_b (one cycle) -> WAIT.
//   - WAIT: data_in=0; on gcd_done=1, res_data<=gcd_result -> OUT.
//   - BYPASS: res_data<=op_a|op_b, so gcd(x,0)=x and gcd(0,0)=0 -> OUT.
//     start is never asserted in this path.
//   - OUT: res_valid=1; res_data held stable until res_ready.
//     On res_valid&&res_ready -> IDLE; res_valid drops the next cycle.
//  - Outside SEND_A/SEND_B, data_in=0. start is asserted only in SEND_A.
//  - Latency: pair accepted at edge t, start asserted in cycle t+2, op_b driven in t+3.
//    Result is registered the edge after gcd_done; BYPASS result is valid at t+3.
//  - gcd_done outside WAIT is ignored.
//  - One job is in flight at a time; the FIFO keeps accepting pairs meanwhile.
//  - Reset mid-operation aborts the job: FIFO contents lost, no partial result emitted.
//  - All outputs are registered except in_ready and busy (decoded from registered state).
// STRUCTURE
//  - gcd_pkg: GCD_WIDTH=16, feeder state enum/localparams (IDLE, SEND_A, SEND_B,
//    WAIT, BYPASS, OUT); shared with controller for consistent widths.
//  - Sub-module gcd_pair_fifo:
//    - parameters WIDTH*2 data and DEPTH; ports clk, rst_n, push, pop, wdata, rdata, full, empty.
//    - Top level holds the FSM, op registers, and result register.
// TESTING (bench instantiates feeder + controller + gcd_datapath)
//  1. (48,18), res_ready=1 -> start pulses once, data_in 48 then 18;
//     res_valid with res_data=6.
//  2. Back-to-back (7,7),(35,14),(17,5) -> results 7,7,1 in order, each exactly once.
//  3. (0,9),(12,0),(0,0) -> results 9,12,0; start never asserted.
//  4. Hold res_ready=0 and push 6 pairs with DEPTH=4:
//     - in_ready falls after 4 queued plus 1 in the engine; res_data stable.
//     - Release res_ready -> all 6 drain in order.
//  5. Assert rst_n=0 during WAIT of (1000,3):
//     - All outputs return to reset values within the same cycle; busy=0.
//     - After release, new pair (9,6) -> 3.
//  6. Spurious gcd_done in IDLE/OUT -> no state change, no extra res_valid.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine front end and controller.
package gcd_pkg;

    // Operand/result width of the shared datapath bus.
    localparam int unsigned GCD_WIDTH = 16;

    // Default number of operand pairs buffered ahead of the engine.
    localparam int unsigned GCD_FIFO_DEPTH = 4;

    // Feeder sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT   = 3'd3,
        BYPASS = 3'd4,
        OUT    = 3'd5
    } feeder_state_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Small synchronous FIFO holding packed {a, b} operand pairs.
// Registered count; pop and push may coincide; no fall-through.
module gcd_pair_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = AW + 1;

    localparam logic [AW-1:0]    PTR_ONE = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two and count never exceeds it, so the MSB alone flags full.
    assign full  = count[AW];
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage array: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_operand_feeder.sv
// Front end for the subtractive GCD engine: buffers operand pairs, serialises
// them onto data_in with a start pulse, waits for done and returns the result.
// Pairs containing a zero skip the engine and return a|b directly.
module gcd_operand_feeder
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned DEPTH = GCD_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] data_in,
    output logic             start,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    feeder_state_t      state;
    feeder_state_t      state_nxt;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   op_a_nxt;
    logic [WIDTH-1:0]   op_b_nxt;

    logic               start_nxt;
    logic [WIDTH-1:0]   data_in_nxt;
    logic               res_valid_nxt;
    logic [WIDTH-1:0]   res_data_nxt;

    logic               fifo_push;
    logic               fifo_pop;
    logic [2*WIDTH-1:0] fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WIDTH-1:0]   head_a;
    logic [WIDTH-1:0]   head_b;

    assign fifo_push = in_valid && !fifo_full;
    assign head_a    = fifo_rdata[2*WIDTH-1:WIDTH];
    assign head_b    = fifo_rdata[WIDTH-1:0];

    gcd_pair_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({in_a, in_b}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;

    // Next-state and next-output decode; outputs are computed from the next
    // state so they can be registered and still line up with the state.
    always_comb begin
        state_nxt    = state;
        op_a_nxt     = op_a;
        op_b_nxt     = op_b;
        res_data_nxt = res_data;
        fifo_pop     = 1'b0;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    op_a_nxt = head_a;
                    op_b_nxt = head_b;
                    if ((head_a == '0) || (head_b == '0)) begin
                        state_nxt = BYPASS;
                    end else begin
                        state_nxt = SEND_A;
                    end
                end
            end
            SEND_A: state_nxt = SEND_B;
            SEND_B: state_nxt = WAIT;
            WAIT: begin
                if (gcd_done) begin
                    res_data_nxt = gcd_result;
                    state_nxt    = OUT;
                end
            end
            BYPASS: begin
                // gcd(x,0)=x and gcd(0,0)=0 both reduce to a bitwise OR.
                res_data_nxt = op_a | op_b;
                state_nxt    = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        start_nxt     = (state_nxt == SEND_A);
        res_valid_nxt = (state_nxt == OUT);
        data_in_nxt   = '0;
        if (state_nxt == SEND_A) begin
            data_in_nxt = op_a_nxt;
        end else if (state_nxt == SEND_B) begin
            data_in_nxt = op_b_nxt;
        end
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            start     <= 1'b0;
            data_in   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            state     <= state_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            start     <= start_nxt;
            data_in   <= data_in_nxt;
            res_valid <= res_valid_nxt;
            res_data  <= res_data_nxt;
        end
    end

endmodule

// File: tb/tb_gcd_operand_feeder.sv
// Bench for gcd_operand_feeder with a behavioural subtractive GCD engine.
module tb_gcd_operand_feeder;

    localparam int unsigned W = 16;
    localparam int unsigned D = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] data_in;
    logic         start;
    logic         gcd_done;
    logic [W-1:0] gcd_result;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         busy;

    always #5 clk = ~clk;

    gcd_operand_feeder #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .data_in    (data_in),
        .start      (start),
        .gcd_done   (gcd_done),
        .gcd_result (gcd_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference GCD by Euclid's remainder method.
    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] t;
        a = a_in;
        b = b_in;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine arithmetic: repeated subtraction, only ever given nonzero operands.
    function automatic logic [W-1:0] sub_gcd(input logic [W-1:0] a_in, input logic [W-1:0] b_in);
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = a_in;
        b = b_in;
        while (a != b && a != 0 && b != 0) begin
            if (a > b) a = a - b;
            else       b = b - a;
        end
        return a;
    endfunction

    // Behavioural engine: captures A on start, B the next cycle, answers later.
    logic         spur = 1'b0;
    logic [W-1:0] spur_val = '0;
    initial begin
        int           phase;
        int           cnt;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         edone;
        phase      = 0;
        cnt        = 0;
        ea         = '0;
        eb         = '0;
        gcd_done   = 1'b0;
        gcd_result = '0;
        forever begin
            @(posedge clk);
            #2;
            edone = 1'b0;
            if (!rst_n) begin
                phase = 0;
            end else begin
                case (phase)
                    0: if (start) begin ea = data_in; phase = 1; end
                    1: begin eb = data_in; cnt = 3; phase = 2; end
                    default: begin
                        if (cnt == 0) begin edone = 1'b1; phase = 0; end
                        else cnt--;
                    end
                endcase
            end
            gcd_done   = edone | spur;
            gcd_result = edone ? sub_gcd(ea, eb) : (spur ? spur_val : '0);
        end
    end

    // Outstanding jobs in acceptance order; results observed at handshakes.
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } pair_t;

    pair_t        jobs[$];
    logic [W-1:0] obs[$];
    int           start_cnt = 0;

    // Per-cycle compare against the queue model, sampled on the falling edge.
    initial begin
        logic         prev_start;
        logic         prev_hold;
        logic [W-1:0] prev_res;
        prev_start = 1'b0;
        prev_hold  = 1'b0;
        prev_res   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                jobs.delete();
                prev_start = 1'b0;
                prev_hold  = 1'b0;
            end else begin
                check("busy", busy, jobs.size() != 0);
                if (start) begin
                    start_cnt++;
                    check("start_job_pending", jobs.size() != 0, 1);
                    if (prev_start) check("start_pulse_width", prev_start, 0);
                    if (jobs.size() != 0) begin
                        check("start_nonzero_pair", (jobs[0].a != 0) && (jobs[0].b != 0), 1);
                        check("data_in_a", data_in, jobs[0].a);
                    end
                end else if (prev_start) begin
                    check("data_in_b", data_in, (jobs.size() != 0) ? jobs[0].b : '0);
                end else begin
                    check("data_in_idle", data_in, 0);
                end
                if (prev_hold) begin
                    check("res_valid_held", res_valid, 1);
                    check("res_data_held", res_data, prev_res);
                end
                if (res_valid && res_ready) begin
                    check("res_job_pending", jobs.size() != 0, 1);
                    if (jobs.size() != 0) begin
                        check("res_data", res_data, ref_gcd(jobs[0].a, jobs[0].b));
                        void'(jobs.pop_front());
                    end
                    obs.push_back(res_data);
                end
                prev_start = start;
                prev_hold  = res_valid && !res_ready;
                prev_res   = res_data;
                if (in_valid && in_ready) begin
                    jobs.push_back('{a: in_a, b: in_b});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok       = 1'b0;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            tick(1);
        end
        in_valid = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 400 && obs.size() < n; i++) tick(1);
        tick(4);
        check("result_count", obs.size(), n);
    endtask

    task automatic wait_res_valid();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (res_valid) seen = 1'b1;
            else tick(1);
        end
        check("res_valid_seen", seen, 1);
    endtask

    initial begin
        int           s0;
        logic         seen;
        logic [W-1:0] exp4 [6];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b1;
        tick(2);

        // Reset values
        check("rst_start", start, 0);
        check("rst_data_in", data_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick(2);

        // 1: single pair through the engine, with latency
        obs.delete();
        s0 = start_cnt;
        push(16'd48, 16'd18);
        check("t1_no_start_yet", start, 0);
        tick(1);
        check("t1_start", start, 1);
        check("t1_data_a", data_in, 48);
        tick(1);
        check("t1_start_low", start, 0);
        check("t1_data_b", data_in, 18);
        wait_obs(1);
        if (obs.size() >= 1) check("t1_result", obs[0], 6);
        check("t1_start_count", start_cnt - s0, 1);

        // 2: back-to-back pairs
        obs.delete();
        push(16'd7, 16'd7);
        push(16'd35, 16'd14);
        push(16'd17, 16'd5);
        wait_obs(3);
        if (obs.size() >= 3) begin
            check("t2_r0", obs[0], 7);
            check("t2_r1", obs[1], 7);
            check("t2_r2", obs[2], 1);
        end

        // 3: zero operands bypass the engine
        obs.delete();
        s0 = start_cnt;
        push(16'd0, 16'd9);
        tick(1);
        check("t3_bypass_not_yet", res_valid, 0);
        tick(1);
        check("t3_bypass_valid", res_valid, 1);
        check("t3_bypass_data", res_data, 9);
        push(16'd12, 16'd0);
        push(16'd0, 16'd0);
        wait_obs(3);
        if (obs.size() >= 3) begin
            check("t3_r0", obs[0], 9);
            check("t3_r1", obs[1], 12);
            check("t3_r2", obs[2], 0);
        end
        check("t3_no_start", start_cnt - s0, 0);

        // 4: backpressure fills the FIFO
        obs.delete();
        exp4 = '{16'd4, 16'd3, 16'd5, 16'd7, 16'd25, 16'd13};
        res_ready = 1'b0;
        push(16'd12, 16'd8);
        push(16'd9, 16'd3);
        push(16'd0, 16'd5);
        push(16'd21, 16'd14);
        push(16'd100, 16'd75);
        check("t4_in_ready_low", in_ready, 0);
        check("t4_busy", busy, 1);
        tick(8);
        check("t4_held_valid", res_valid, 1);
        check("t4_held_data", res_data, 4);
        check("t4_still_full", in_ready, 0);
        res_ready = 1'b1;
        push(16'd13, 16'd0);
        wait_obs(6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs.size()) check("t4_order", obs[i], exp4[i]);
        end

        // 5: reset while waiting on the engine
        obs.delete();
        in_a     = 16'd1000;
        in_b     = 16'd3;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (start) seen = 1'b1;
            else tick(1);
        end
        check("t5_start_seen", seen, 1);
        tick(2);
        check("t5_busy_before", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_start", start, 0);
        check("t5_data_in", data_in, 0);
        check("t5_res_valid", res_valid, 0);
        check("t5_res_data", res_data, 0);
        check("t5_busy", busy, 0);
        check("t5_in_ready", in_ready, 1);
        tick(2);
        rst_n = 1'b1;
        tick(10);
        check("t5_no_result", obs.size(), 0);
        push(16'd9, 16'd6);
        wait_obs(1);
        if (obs.size() >= 1) check("t5_result", obs[0], 3);

        // 6: spurious gcd_done in IDLE and in OUT
        obs.delete();
        spur_val = 16'h1234;
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        tick(3);
        check("t6_idle_valid", res_valid, 0);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_obs", obs.size(), 0);
        res_ready = 1'b0;
        push(16'd20, 16'd15);
        wait_res_valid();
        spur_val = 16'h4321;
        spur = 1'b1;
        tick(1);
        spur = 1'b0;
        tick(3);
        check("t6_out_data", res_data, 5);
        res_ready = 1'b1;
        wait_obs(1);
        if (obs.size() >= 1) check("t6_result", obs[0], 5);
        check("t6_valid_dropped", res_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
